// File: rtl/cond_entradas.sv
// Input conditioning for the vehicle control panel: per-lane synchroniser and debounce counter for
// 8 switches and 4 buttons, plus press/change strobes. COND_ENTRADAS_BTN_TOGGLE_EN makes buttons toggle.
module cond_entradas #(
  parameter int DEB_CYCLES  = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] SW_IN,
  input  logic [3:0] BT_IN,
  output logic [7:0] CH,
  output logic [3:0] B,
  output logic [3:0] B_RISE,
  output logic       CHG
);
  localparam int N_SW  = 8;
  localparam int N_BT  = 4;
  localparam int LANES = N_SW + N_BT;
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("DEB_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end

  logic [LANES-1:0] w_raw;
  logic [LANES-1:0] r_sync [SYNC_STAGES];
  logic [LANES-1:0] w_s;
  logic [LANES-1:0] r_d;
  logic [CNT_W-1:0] r_cnt [LANES];
  logic [LANES-1:0] w_upd;
  logic [N_BT-1:0]  w_rise;
  logic             w_chg;
  logic [N_BT-1:0]  r_rise;
  logic             r_chg;

  // Lanes 0..7 are switches, 8..11 are buttons.
  assign w_raw = {BT_IN, SW_IN};
  assign w_s   = r_sync[SYNC_STAGES-1];

  // Synchroniser stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  always_comb begin
    w_upd = '0;
    for (int l = 0; l < LANES; l++) begin
      w_upd[l] = (w_s[l] != r_d[l]) && (r_cnt[l] == CNT_MAX);
    end
  end

  // Debounce stage: the counter only climbs while s disagrees with d, so it never passes CNT_MAX.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_d <= '0;
      for (int l = 0; l < LANES; l++) r_cnt[l] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (w_s[l] == r_d[l]) begin
          r_cnt[l] <= '0;
        end else if (w_upd[l]) begin
          r_d[l]   <= w_s[l];
          r_cnt[l] <= '0;
        end else begin
          r_cnt[l] <= r_cnt[l] + CNT_W'(1);
        end
      end
    end
  end

  assign w_rise = w_upd[LANES-1:N_SW] & w_s[LANES-1:N_SW];

`ifdef COND_ENTRADAS_BTN_TOGGLE_EN
  logic [N_BT-1:0] r_tog;

  // Button releases are invisible on B in toggle mode, so they must not raise CHG either.
  assign w_chg = (|w_upd[N_SW-1:0]) | (|w_rise);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_tog <= '0;
    else        r_tog <= r_tog ^ w_rise;
  end

  assign B = r_tog;
`else
  assign w_chg = |w_upd;
  assign B     = r_d[LANES-1:N_SW];
`endif

  // Strobe stage: registered on the same edge that updates d.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rise <= '0;
      r_chg  <= 1'b0;
    end else begin
      r_rise <= w_rise;
      r_chg  <= w_chg;
    end
  end

  assign CH     = r_d[N_SW-1:0];
  assign B_RISE = r_rise;
  assign CHG    = r_chg;

endmodule

// File: tb/tb_cond_entradas.sv
// Randomised and directed bench for cond_entradas (DEB_CYCLES=4, SYNC_STAGES=2) against a
// sample-history reference model: a lane flips once its last DEB synchronised samples all disagree.
module tb_cond_entradas;
  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int HIST = DEB + SYNC - 1;
`ifdef COND_ENTRADAS_BTN_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] SW_IN = '0;
  logic [3:0] BT_IN = '0;
  logic [7:0] CH;
  logic [3:0] B;
  logic [3:0] B_RISE;
  logic       CHG;

  int n_checks = 0;
  int n_errors = 0;
  int ecount   = 0;
  int chg_seen = 0;
  int rise_seen [4];

  // Reference model state
  logic [11:0] samp [$];
  logic [11:0] m_d;
  logic [3:0]  m_tog;
  logic [3:0]  m_rise;
  logic        m_chg;

  cond_entradas #(.DEB_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW_IN(SW_IN), .BT_IN(BT_IN),
    .CH(CH), .B(B), .B_RISE(B_RISE), .CHG(CHG)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    samp.delete();
    for (int i = 0; i < HIST; i++) samp.push_back(12'h000);
    m_d = '0; m_tog = '0; m_rise = '0; m_chg = 1'b0;
  endfunction

  // samp[0..DEB-1] are the values the synchroniser presents on the last DEB edges.
  function automatic void model_step(input logic [11:0] raw);
    logic [11:0] flip;
    samp.push_back(raw);
    flip = '1;
    for (int i = 0; i < DEB; i++) flip &= samp[i] ^ m_d;
    void'(samp.pop_front());
    m_rise = flip[11:8] & ~m_d[11:8];
    m_chg  = TOG ? ((|flip[7:0]) | (|m_rise)) : (|flip);
    m_tog  = m_tog ^ m_rise;
    m_d    = m_d ^ flip;
  endfunction

  task automatic check_outputs(input string ph);
    logic [3:0] eb;
    eb = TOG ? m_tog : m_d[11:8];
    check({ph, "_CH"},     32'(CH),     32'(m_d[7:0]));
    check({ph, "_B"},      32'(B),      32'(eb));
    check({ph, "_B_RISE"}, 32'(B_RISE), 32'(m_rise));
    check({ph, "_CHG"},    32'(CHG),    32'(m_chg));
    if (CHG) chg_seen++;
    for (int j = 0; j < 4; j++) if (B_RISE[j]) rise_seen[j]++;
  endtask

  task automatic clear_tallies();
    chg_seen = 0;
    for (int j = 0; j < 4; j++) rise_seen[j] = 0;
  endtask

  // Called at a falling edge; releases reset at the next falling edge.
  task automatic do_reset(input string ph);
    RST_N = 1'b0;
    #1;
    model_reset();
    check({ph, "_rst_CH"},     32'(CH),     32'h0);
    check({ph, "_rst_B"},      32'(B),      32'h0);
    check({ph, "_rst_B_RISE"}, 32'(B_RISE), 32'h0);
    check({ph, "_rst_CHG"},    32'(CHG),    32'h0);
    @(posedge CLK);
    @(negedge CLK);
    check_outputs({ph, "_rst_hold"});
    RST_N = 1'b1;
    ecount = 0;
    clear_tallies();
  endtask

  task automatic cyc(input string ph, input logic [7:0] sw, input logic [3:0] bt);
    SW_IN = sw;
    BT_IN = bt;
    @(posedge CLK);
    model_step({bt, sw});
    ecount++;
    @(negedge CLK);
    check_outputs(ph);
  endtask

  initial begin
    logic [7:0] rs;
    logic [3:0] rb;
    model_reset();
    @(negedge CLK);

    // 1: switches held high through reset
    SW_IN = 8'hFF;
    do_reset("t1");
    for (int k = 0; k < 8; k++) begin
      cyc("t1", 8'hFF, 4'h0);
      check("t1_CH_abs", 32'(CH), (ecount < 6) ? 32'h00 : 32'hFF);
      check("t1_CHG_abs", 32'(CHG), 32'(ecount == 6));
    end
    check("t1_chg_count", 32'(chg_seen), 32'd1);

    // 2: 3-cycle glitch on SW_IN[3]
    SW_IN = 8'h00;
    do_reset("t2");
    for (int k = 0; k < 3; k++) cyc("t2", 8'h08, 4'h0);
    for (int k = 0; k < 8; k++) cyc("t2", 8'h00, 4'h0);
    check("t2_CH3", 32'(CH[3]), 32'd0);
    check("t2_chg_count", 32'(chg_seen), 32'd0);

    // 3: BT_IN[1] chatters every cycle, then settles high
    do_reset("t3");
    for (int k = 0; k < 10; k++) cyc("t3", 8'h00, (k % 2 == 0) ? 4'h2 : 4'h0);
    check("t3_B1_chatter", 32'(B[1]), 32'd0);
    ecount = 0;
    for (int k = 0; k < 10; k++) begin
      cyc("t3", 8'h00, 4'h2);
      if (ecount == 5) check("t3_B1_e5", 32'(B[1]), 32'd0);
      if (ecount == 6) check("t3_B1_e6", 32'(B[1]), 32'd1);
    end
    check("t3_rise_count", 32'(rise_seen[1]), 32'd1);

    // 4: simultaneous switch and button change
    do_reset("t4");
    for (int k = 0; k < 4; k++) cyc("t4", 8'h00, 4'h0);
    ecount = 0;
    for (int k = 0; k < 8; k++) begin
      cyc("t4", 8'h80, 4'h1);
      if (ecount == 5) check("t4_e5", 32'({CH[7], B[0]}), 32'b00);
      if (ecount == 6) begin
        check("t4_e6", 32'({CH[7], B[0]}), 32'b11);
        check("t4_rise", 32'(B_RISE), 32'b0001);
      end
    end
    check("t4_chg_count", 32'(chg_seen), 32'd1);

    // 5: reset in mid-count with the input still high
    do_reset("t5");
    for (int k = 0; k < 3; k++) cyc("t5", 8'h20, 4'h0);
    do_reset("t5b");
    for (int k = 0; k < 8; k++) begin
      cyc("t5", 8'h20, 4'h0);
      if (ecount == 5) check("t5_CH5_e5", 32'(CH[5]), 32'd0);
      if (ecount == 6) check("t5_CH5_e6", 32'(CH[5]), 32'd1);
    end

    // 6: two clean presses on BT_IN[2]
    do_reset("t6");
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 8; k++) cyc("t6", 8'h00, 4'h4);
      check("t6_press", 32'(B[2]), TOG ? 32'(p == 0) : 32'd1);
      for (int k = 0; k < 8; k++) cyc("t6", 8'h00, 4'h0);
      check("t6_release", 32'(B[2]), TOG ? 32'(p == 0) : 32'd0);
    end
    check("t6_chg_count", 32'(chg_seen), TOG ? 32'd2 : 32'd4);
    check("t6_rise_count", 32'(rise_seen[2]), 32'd2);

    // Random chatter on all lanes with occasional resets
    rs = '0;
    rb = '0;
    for (int k = 0; k < 800; k++) begin
      rs = rs ^ 8'($urandom & $urandom & $urandom);
      rb = rb ^ 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 249) == 0) begin
        SW_IN = rs;
        BT_IN = rb;
        do_reset("rnd");
      end
      cyc("rnd", rs, rb);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cond_entradas.md
# cond_entradas

Input-conditioning stage that sits directly upstream of the dual-interface vehicle control panel (interfaces IE01/IE02). It takes the raw board switches (CH7..CH0) and push-buttons (B3..B0) and synchronises them into the clock domain. It then debounces each line with an independent counter and presents clean levels to the panel's combinational profile/function/priority logic. It also emits one-cycle change and press strobes for downstream sequential consumers.

## Interface
- `DEB_CYCLES`, default 50000: consecutive stable synchronised cycles required before an output follows its input. Legal range is ≥ 2.
- `SYNC_STAGES`, default 2: flip-flop depth of the synchroniser on every line. Legal range is ≥ 2.
- `CLK` input, 1 bit: the single clock. All flops are rising-edge.
- `RST_N` input, 1 bit: asynchronous, active-low reset.
- `SW_IN` input, 8 bits: raw switches, where bit 7 is CH7 and bit 0 is CH0.
- `BT_IN` input, 4 bits: raw buttons, where bit 3 is B3 and bit 0 is B0.
- `CH` output, 8 bits: debounced switch levels that feed CH7..CH0 of the panel.
- `B` output, 4 bits: debounced button levels, or toggled states when toggle mode is compiled in. Feeds B3..B0 of the panel.
- `B_RISE` output, 4 bits: one-cycle pulse on each debounced 0→1 transition of a button.
- `CHG` output, 1 bit: one-cycle pulse when any bit of `CH` or `B` changes.

## Operation
- There are 12 independent lanes: 8 switches and 4 buttons. Each lane is built identically.
- **Synchroniser:** a `SYNC_STAGES`-deep flop chain. The lane's synchronised value `s` is the last stage.
- **Debounce register:** each lane holds a stable value `d` and a counter `cnt` of width clog2(`DEB_CYCLES`). The counter saturates by construction and never wraps.
- Each edge, the lane updates as follows:
  - If `s == d`: `cnt <= 0`.
  - If `s != d` and `cnt == DEB_CYCLES-1`: `d <= s` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
- **Glitch rejection:** any mismatch shorter than `DEB_CYCLES` consecutive cycles clears `cnt` and never reaches `d`.
- **Switch lanes:** `CH[i] = d`.
- **Button lanes:** `B[j] = d`. `B_RISE[j]` is registered high for exactly one cycle on the edge where `d` goes 0→1.
- **`CHG`:** registered high for exactly one cycle on the edge where any `CH`/`B` bit updates. Multiple lanes updating on the same edge produce a single one-cycle `CHG`.
- **Reset values:** all sync flops, `d`, `cnt`, `CH`, `B`, `B_RISE` and `CHG` are 0.
  - Asserting `RST_N` forces these values immediately, regardless of `CLK`, including in mid-count.
- **After reset release:** an input held at 1 propagates as a normal debounced change. This includes a `CHG` pulse, and a `B_RISE` pulse on button lanes.
- **No cross-lane interaction:** lanes operate independently apart from the `CHG` OR.

## Timing
- **Latency:** take a raw change that stays stable, and call edge 1 the first rising edge that samples the new value. The output changes on edge `SYNC_STAGES + DEB_CYCLES`.
  - With defaults this is 50002 cycles.
- `B_RISE` and `CHG` assert on that same edge and deassert on the next edge.
- **Repeated toggles:** an input toggling with a period ≤ 2·(`DEB_CYCLES`−1) cycles never changes the output.
- **Simultaneous lane changes:** lanes whose changes are sampled on the same edge update on the same edge.
- **Reset release:** the first counting edge is the first rising edge after `RST_N` goes high. No output toggles on the release itself.
- **Throughput:** a lane can change at most once every `DEB_CYCLES` cycles.

## Configuration
- Macro: `COND_ENTRADAS_BTN_TOGGLE_EN`.
- **Defined:** each `B[j]` is a toggle flop, reset to 0, that inverts on every `B_RISE[j]`.
  - Releasing the button does not change `B[j]`.
  - `CHG` pulses on every toggle, but not on debounced releases.
  - `B_RISE` behaves as without the macro.
- **Undefined:** `B[j]` follows the debounced button level.
- Switch lanes are unaffected in both cases.

## Test plan
All scenarios use `DEB_CYCLES`=4 and `SYNC_STAGES`=2.

1. Hold `SW_IN`=8'hFF during reset, then release → `CH`=8'h00 until edge 6 after release, `CH`=8'hFF from edge 6, and `CHG` high for exactly that one cycle.
2. Drive `SW_IN[3]` high for 3 cycles, then low → `CH[3]` stays 0 and `CHG` never asserts.
3. Toggle `BT_IN[1]` every cycle for 10 cycles, then hold it at 1 → `B[1]` rises 6 edges after the final 0→1 is sampled, and `B_RISE[1]` pulses exactly once.
4. Change `SW_IN[7]` 0→1 and `BT_IN[0]` 0→1 in the same cycle → `CH[7]` and `B[0]` update on the same edge, `CHG` is a single one-cycle pulse, and `B_RISE`=4'b0001.
5. Raise `SW_IN[5]`, then assert `RST_N` after 3 cycles for one cycle with the input still high → outputs are 0 immediately, and `CH[5]` rises 6 edges after release.
6. With `COND_ENTRADAS_BTN_TOGGLE_EN` defined, apply two clean presses on `BT_IN[2]` (each held 8 cycles, with 8 cycles released between them) → `B[2]` goes 0→1 on the first press and 1→0 on the second, releases cause no change, and there are two `CHG` pulses in total.
